pattern_feeder: RTL and testbench

//  Parametrised test-pattern source that writes words into the FT600 TX FIFO write port (en/out/full).

---
 rtl/pattern_feeder_if.sv | 10 +
 rtl/pattern_feeder.sv | 134 +++++++++++++
 tb/tb_pattern_feeder.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/pattern_feeder_if.sv
// pattern_feeder_if: FT600 TX FIFO write port (en/out/full)
interface pattern_feeder_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  en;
  logic [DATA_WIDTH-1:0] out;
  logic                  full;
  modport master(output en, output out, input full);
  modport slave(input en, input out, output full);
endinterface

// File: rtl/pattern_feeder.sv
// pattern_feeder: test-pattern source writing words into the FT600 TX FIFO under full back-pressure
module pattern_feeder #(
  parameter int                    DATA_WIDTH  = 16,
  parameter int                    LANE_WIDTH  = 8,
  parameter int                    GAP_WIDTH   = 4,
  parameter int                    BURST_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_TAPS   = 16'hB400,
  parameter logic [DATA_WIDTH-1:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic [1:0]             mode,
  input  logic [GAP_WIDTH-1:0]   gap,
  input  logic [BURST_WIDTH-1:0] burst_len,
  pattern_feeder_if.master       fifo,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] word_count
);
  localparam int LANES = DATA_WIDTH / LANE_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ALT0 = {DATA_WIDTH/2{2'b01}};
  localparam logic [DATA_WIDTH-1:0] ALT1 = {DATA_WIDTH/2{2'b10}};
  typedef enum logic [1:0] {IDLE, RUN, GAP, DONE} state_t;
  state_t                 state_q, state_d;
  logic                   en_q, en_d, done_q, done_d, par_q, par_d;
  logic [DATA_WIDTH-1:0]  out_q, out_d, walk_q, walk_d, lfsr_q, lfsr_d, cnt_w;
  logic [LANE_WIDTH-1:0]  base_q, base_d;
  logic [BURST_WIDTH-1:0] wc_q, wc_d, len_q, len_d;
  logic [GAP_WIDTH-1:0]   gap_q, gap_d, gcnt_q, gcnt_d;
  logic [1:0]             mode_q, mode_d;
  logic                   acc;
  assign acc        = en_q && !fifo.full;
  assign fifo.en    = en_q;
  assign fifo.out   = out_q;
  assign busy       = state_q == RUN || state_q == GAP;
  assign done       = done_q;
  assign word_count = wc_q;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign cnt_w[k*LANE_WIDTH +: LANE_WIDTH] = base_d + LANE_WIDTH'(k);
  end
  // Next state, handshake and pattern-state advance; pattern state moves only on acceptance
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    done_d  = 1'b0;
    wc_d    = acc ? wc_q + 1'b1 : wc_q;
    base_d  = acc ? base_q + LANE_WIDTH'(LANES) : base_q;
    walk_d  = acc ? {walk_q[DATA_WIDTH-2:0], walk_q[DATA_WIDTH-1]} : walk_q;
    lfsr_d  = acc ? (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0) : lfsr_q;
    par_d   = acc ? ~par_q : par_q;
    mode_d  = mode_q;
    gap_d   = gap_q;
    len_d   = len_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        en_d    = 1'b1;
        mode_d  = mode;
        gap_d   = gap;
        len_d   = burst_len;
        wc_d    = '0;
        base_d  = '0;
        walk_d  = DATA_WIDTH'(1);
        lfsr_d  = LFSR_SEED;
        par_d   = 1'b0;
      end
      RUN: if (stop) begin
        state_d = IDLE;
        en_d    = 1'b0;
      end else if (acc && len_q != '0 && wc_d == len_q) begin
        state_d = DONE;
        en_d    = 1'b0;
        done_d  = 1'b1;
      end else if (acc && gap_q != '0) begin
        state_d = GAP;
        en_d    = 1'b0;
        gcnt_d  = gap_q;
      end
      GAP: if (stop) begin
        state_d = IDLE;
      end else if (gcnt_q == GAP_WIDTH'(1)) begin
        state_d = RUN;
        en_d    = 1'b1;
      end else begin
        gcnt_d = gcnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Word data: registered alongside en so out is stable while full holds the word
  always_comb begin
    out_d = out_q;
    if (en_d)
      out_d = mode_d == 2'd0 ? cnt_w :
              mode_d == 2'd1 ? lfsr_d :
              mode_d == 2'd2 ? walk_d :
              par_d ? ALT1 : ALT0;
  end
  // State and datapath registers with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      out_q   <= '0;
      done_q  <= 1'b0;
      wc_q    <= '0;
      base_q  <= '0;
      walk_q  <= DATA_WIDTH'(1);
      lfsr_q  <= LFSR_SEED;
      par_q   <= 1'b0;
      mode_q  <= '0;
      gap_q   <= '0;
      len_q   <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      out_q   <= out_d;
      done_q  <= done_d;
      wc_q    <= wc_d;
      base_q  <= base_d;
      walk_q  <= walk_d;
      lfsr_q  <= lfsr_d;
      par_q   <= par_d;
      mode_q  <= mode_d;
      gap_q   <= gap_d;
      len_q   <= len_d;
      gcnt_q  <= gcnt_d;
    end
  end
endmodule

// File: tb/tb_pattern_feeder.sv
// tb_pattern_feeder: directed self-checking bench for pattern_feeder
module tb_pattern_feeder;
  logic        clk = 1'b0, rst_n = 1'b1, start = 1'b0, stop = 1'b0;
  logic [1:0]  mode = '0;
  logic [3:0]  gap = '0;
  logic [15:0] burst_len = '0;
  logic        busy, done;
  logic [15:0] word_count;
  int          total = 0, bad = 0;
  always #5 clk = ~clk;
  pattern_feeder_if #(.DATA_WIDTH(16)) f();
  pattern_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .gap(gap),
    .burst_len(burst_len), .fifo(f.master), .busy(busy), .done(done), .word_count(word_count)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic go(input logic [1:0] m, input logic [3:0] g, input logic [15:0] l);
    mode = m;
    gap = g;
    burst_len = l;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  logic [15:0] t1[4] = '{16'h0100, 16'h0302, 16'h0504, 16'h0706};
  logic [15:0] t2[3] = '{16'hACE1, 16'hE270, 16'h7138};
  logic        t4e[9] = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
  logic [15:0] t4o[9] = '{16'h0001, 0, 0, 0, 16'h0002, 0, 0, 0, 16'h0004};
  logic [7:0]  b;
  initial begin
    f.full = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst en", f.en, 0);
    chk("rst out", f.out, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst wc", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    go(2'd0, 4'd0, 16'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t1 en", f.en, 1);
      chk("t1 out", f.out, t1[i]);
      chk("t1 done", done, 0);
      tick();
    end
    chk("t1 en end", f.en, 0);
    chk("t1 done", done, 1);
    chk("t1 wc", word_count, 4);
    tick();
    chk("t1 done2", done, 0);
    chk("t1 busy", busy, 0);
    chk("t1 wc hold", word_count, 4);
    go(2'd1, 4'd0, 16'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t2 en", f.en, 1);
      chk("t2 out", f.out, t2[i]);
      tick();
    end
    chk("t2 done", done, 1);
    chk("t2 wc", word_count, 3);
    tick();
    go(2'd0, 4'd0, 16'd0);
    chk("t3 w0", f.out, 16'h0100);
    tick();
    chk("t3 w1", f.out, 16'h0302);
    f.full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t3 hold en", f.en, 1);
      chk("t3 hold out", f.out, 16'h0302);
      chk("t3 hold wc", word_count, 1);
    end
    f.full = 1'b0;
    tick();
    chk("t3 w2", f.out, 16'h0504);
    chk("t3 wc2", word_count, 2);
    tick();
    chk("t3 w3", f.out, 16'h0706);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("t3 stop en", f.en, 0);
    chk("t3 stop wc", word_count, 4);
    chk("t3 stop busy", busy, 0);
    chk("t3 stop done", done, 0);
    go(2'd2, 4'd3, 16'd3);
    mode = 2'd0;
    gap = 4'd0;
    burst_len = 16'd9;
    for (int i = 0; i < 9; i++) begin
      start = (i == 2);
      chk("t4 en", f.en, t4e[i]);
      chk("t4 busy", busy, 1);
      if (t4e[i]) chk("t4 out", f.out, t4o[i]);
      tick();
    end
    start = 1'b0;
    chk("t4 done", done, 1);
    chk("t4 wc", word_count, 3);
    tick();
    go(2'd3, 4'd0, 16'd0);
    for (int i = 0; i < 130; i++) begin
      chk("t5 alt", f.out, i[0] ? 16'hAAAA : 16'h5555);
      stop = (i == 129);
      tick();
    end
    stop = 1'b0;
    chk("t5 en", f.en, 0);
    chk("t5 wc", word_count, 130);
    chk("t5 busy", busy, 0);
    chk("t5 done", done, 0);
    tick();
    chk("t5 done2", done, 0);
    go(2'd0, 4'd0, 16'd0);
    for (int i = 0; i < 130; i++) begin
      b = 8'(2 * i);
      chk("t5 cnt", f.out, {b + 8'd1, b});
      stop = (i == 129);
      tick();
    end
    stop = 1'b0;
    chk("t5 cnt wc", word_count, 130);
    go(2'd0, 4'd0, 16'd0);
    tick();
    tick();
    f.full = 1'b1;
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6 en", f.en, 0);
    chk("t6 out", f.out, 0);
    chk("t6 busy", busy, 0);
    chk("t6 done", done, 0);
    chk("t6 wc", word_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    f.full = 1'b0;
    go(2'd0, 4'd0, 16'd0);
    chk("t6 w0", f.out, 16'h0100);
    chk("t6 wc0", word_count, 0);
    tick();
    chk("t6 w1", f.out, 16'h0302);
    chk("t6 wc1", word_count, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
